// File: rtl/fpu_operand_sequencer.sv
// Operand FIFO, hold sequencer and result collector for the handshake-less adder FPU.
// Define FPU_SEQ_STATS_EN to build the saturating inexact/overflow/underflow counters.
`timescale 1ns/1ps
module fpu_operand_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 72
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op_a,
    input  logic [31:0] in_op_b,
    output logic [31:0] op_A_out,
    output logic [31:0] op_B_out,
    input  logic [31:0] fpu_data_in,
    input  logic [3:0]  fpu_status_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_status,
    output logic        busy,
    output logic [7:0]  cnt_inexact,
    output logic [7:0]  cnt_overflow,
    output logic [7:0]  cnt_underflow
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
    } operand_pair_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_OUTPUT
    } state_t;

    state_t             state;
    operand_pair_t      fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               push;
    logic               pop;
    logic               capture;

    // Handshake and sequencing strobes, all decoded from registered state.
    always_comb begin
        in_ready = (count != CNT_W'(DEPTH));
        push     = in_valid && in_ready;
        pop      = (state == S_IDLE) && (count != '0);
        capture  = (state == S_HOLD) && (hold_cnt == '0);
    end

    always_ff @(posedge clock100KHz) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op_a: in_op_a, op_b: in_op_b};
        end
    end

    // FIFO bookkeeping plus the IDLE -> HOLD -> OUTPUT transaction sequencer.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_cnt   <= '0;
            op_A_out   <= '0;
            op_B_out   <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_status <= '0;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        op_A_out <= fifo_mem[rd_ptr].op_a;
                        op_B_out <= fifo_mem[rd_ptr].op_b;
                        hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                        busy     <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (capture) begin
                        res_data   <= fpu_data_in;
                        res_status <= fpu_status_in;
                        res_valid  <= 1'b1;
                        state      <= S_OUTPUT;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FPU_SEQ_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic hit);
        return (hit && (cnt != 8'hFF)) ? cnt + 8'd1 : cnt;
    endfunction

    // Status event counters sample the same status word that is captured.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            cnt_inexact   <= '0;
            cnt_overflow  <= '0;
            cnt_underflow <= '0;
        end else if (capture) begin
            cnt_inexact   <= sat_inc(cnt_inexact,   fpu_status_in[1]);
            cnt_overflow  <= sat_inc(cnt_overflow,  fpu_status_in[2]);
            cnt_underflow <= sat_inc(cnt_underflow, fpu_status_in[3]);
        end
    end
`else
    always_comb begin
        cnt_inexact   = '0;
        cnt_overflow  = '0;
        cnt_underflow = '0;
    end
`endif

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Self-checking bench for fpu_operand_sequencer with a latency-modelling stand-in FPU
// and a transaction-level scoreboard (results in push order, status counters).
`timescale 1ns/1ps
module tb_fpu_operand_sequencer;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned HOLD_CYCLES = 72;
    localparam int          FPU_LAT     = 30;
`ifdef FPU_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock100KHz = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic [31:0] op_A_out;
    logic [31:0] op_B_out;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic        busy;
    logic [7:0]  cnt_inexact;
    logic [7:0]  cnt_overflow;
    logic [7:0]  cnt_underflow;

    always #5 clock100KHz = ~clock100KHz;

    fpu_operand_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clock100KHz   (clock100KHz),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op_a       (in_op_a),
        .in_op_b       (in_op_b),
        .op_A_out      (op_A_out),
        .op_B_out      (op_B_out),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_status    (res_status),
        .busy          (busy),
        .cnt_inexact   (cnt_inexact),
        .cnt_overflow  (cnt_overflow),
        .cnt_underflow (cnt_underflow)
    );

    // Stand-in adder: exact for equal-exponent and cancelling pairs, an arbitrary
    // deterministic scramble (including non-one-hot status) for everything else.
    function automatic logic [35:0] fpu_add(input logic [31:0] a, input logic [31:0] b);
        logic [26:0] sum;
        if ((a[30:0] == b[30:0]) && (a[31] != b[31])) return {4'b0001, 32'h0};
        if ((a[30:25] == b[30:25]) && (a[31] == b[31]) && (a[30:25] != 6'd0)) begin
            if (a[30:25] == 6'h3F) return {4'b0100, 32'h0};
            sum = {2'b01, a[24:0]} + {2'b01, b[24:0]};
            return {(sum[0] ? 4'b0010 : 4'b0001), a[31], a[30:25] + 6'd1, sum[25:1]};
        end
        return {a[3:0] ^ b[7:4], a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000};
    endfunction

    // The FPU output is garbage until the operands have been stable for FPU_LAT cycles.
    int          stable = 0;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    logic [35:0] fpu_ref;
    always @(posedge clock100KHz) begin
        if ((op_A_out !== prev_a) || (op_B_out !== prev_b)) stable <= 0;
        else if (stable < 1000) stable <= stable + 1;
        prev_a <= op_A_out;
        prev_b <= op_B_out;
    end
    assign fpu_ref       = fpu_add(op_A_out, op_B_out);
    assign fpu_data_in   = (stable >= FPU_LAT) ? fpu_ref[31:0] : {16'hBAD0, 16'(stable)};
    assign fpu_status_in = (stable >= FPU_LAT) ? fpu_ref[35:32] : 4'b1111;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    int          m_inx = 0;
    int          m_ovf = 0;
    int          m_unf = 0;
    int          nacc = 0;
    int          npush = 0;
    bit          last_push;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] cnt_exp(input int m);
        return STATS ? 36'(m) : 36'd0;
    endfunction

    // One clock: scoreboard pushes/accepts decided by pre-edge handshake values.
    task automatic cycle();
        logic        pushed;
        logic        accepted;
        logic        stalled;
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] held;
        logic [35:0] r;
        pushed   = in_valid && in_ready;
        accepted = res_valid && res_ready;
        stalled  = res_valid && !res_ready;
        a        = in_op_a;
        b        = in_op_b;
        held     = {res_status, res_data};
        @(posedge clock100KHz);
        #1;
        last_push = pushed;
        if (pushed) begin
            r = fpu_add(a, b);
            exp_q.push_back(r);
            npush++;
            if (r[33] && m_inx < 255) m_inx++;
            if (r[34] && m_ovf < 255) m_ovf++;
            if (r[35] && m_unf < 255) m_unf++;
        end
        if (accepted) begin
            nacc++;
            chk("result_expected", 36'(exp_q.size() != 0), 36'd1);
            if (exp_q.size() != 0) chk("result_order", held, exp_q.pop_front());
        end
        if (stalled) begin
            chk("stall_valid", 36'(res_valid), 36'd1);
            chk("stall_hold", {res_status, res_data}, held);
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic [3:0] exp_s);
        int k;
        in_valid  = 1'b1;
        in_op_a   = a;
        in_op_b   = b;
        res_ready = 1'b1;
        chk({tag, "_in_ready"}, 36'(in_ready), 36'd1);
        cycle();
        in_valid = 1'b0;
        k = 0;
        while (!res_valid && k < 500) begin
            cycle();
            k++;
            if (k == 1) begin
                chk({tag, "_op_a"}, 36'(op_A_out), 36'(a));
                chk({tag, "_op_b"}, 36'(op_B_out), 36'(b));
                chk({tag, "_busy"}, 36'(busy), 36'd1);
            end
        end
        chk({tag, "_latency"}, 36'(k), 36'(HOLD_CYCLES + 1));
        chk({tag, "_data"}, 36'(res_data), 36'(exp_d));
        chk({tag, "_status"}, 36'(res_status), 36'(exp_s));
        cycle();
        chk({tag, "_valid_clr"}, 36'(res_valid), 36'd0);
        chk({tag, "_busy_clr"}, 36'(busy), 36'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] first_a;
    int          base;
    int          sent;
    int          seen;
    int          occ;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op_a   = '0;
        in_op_b   = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clock100KHz);
        #1;
        chk("rst_res_valid", 36'(res_valid), 36'd0);
        chk("rst_in_ready", 36'(in_ready), 36'd1);
        chk("rst_busy", 36'(busy), 36'd0);
        chk("rst_ops", 36'({op_A_out, op_B_out} != 64'd0), 36'd0);
        chk("rst_result", {res_status, res_data}, 36'd0);
        chk("rst_counters", 36'({cnt_inexact, cnt_overflow, cnt_underflow}), 36'd0);
        reset = 1'b1;
        repeat (2) cycle();

        run_one("t1_two_plus_two", 32'h40000000, 32'h40000000, 32'h42000000, 4'b0001);
        run_one("t2_cancel", 32'h40000000, 32'hC0000000, 32'h00000000, 4'b0001);
        run_one("t3_overflow", 32'h7E000000, 32'h7E000000, 32'h00000000, 4'b0100);
        chk("t3_cnt_overflow", 36'(cnt_overflow), STATS ? 36'd1 : 36'd0);
        chk("t3_cnt_inexact", 36'(cnt_inexact), cnt_exp(m_inx));

        // Stall: five distinct pairs with no downstream acceptance.
        res_ready = 1'b0;
        first_a   = {1'b0, 6'd21, 25'd1};
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_op_a  = {1'b0, 6'(20 + k), 25'(k)};
            in_op_b  = {1'b0, 6'(20 + k), 25'(3 * k + 1)};
            cycle();
            occ = (k == 1) ? 1 : k - 1;
            chk($sformatf("stall_push%0d_accepted", k), 36'(last_push), 36'd1);
            chk($sformatf("stall_push%0d_in_ready", k), 36'(in_ready), 36'(occ != DEPTH));
        end
        in_op_a = 32'h12345678;
        in_op_b = 32'h9ABCDEF0;
        repeat (5) begin
            cycle();
            chk("full_no_push", 36'(last_push), 36'd0);
            chk("full_in_ready", 36'(in_ready), 36'd0);
        end
        in_valid = 1'b0;
        seen = 0;
        while (!res_valid && seen < HOLD_CYCLES + 10) begin
            cycle();
            seen++;
        end
        chk("stall_first_valid", 36'(res_valid), 36'd1);
        chk("stall_ops_held", 36'(op_A_out), 36'(first_a));
        repeat (20) cycle();
        base = nacc;
        res_ready = 1'b1;
        for (int c = 0; c < 5 * (HOLD_CYCLES + 3) + 50 && (nacc - base) < 5; c++) cycle();
        chk("stall_drain_count", 36'(nacc - base), 36'd5);
        chk("stall_drain_empty", 36'(exp_q.size()), 36'd0);
        chk("stall_in_ready", 36'(in_ready), 36'd1);

        // Reset in the middle of HOLD with two pairs still queued.
        res_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_op_a = {1'b0, 6'd40, 25'(k + 7)};
            in_op_b = {1'b0, 6'd40, 25'(k + 9)};
            cycle();
        end
        in_valid = 1'b0;
        repeat (10) cycle();
        chk("pre_reset_busy", 36'(busy), 36'd1);
        reset = 1'b0;
        #1;
        chk("mid_reset_valid", 36'(res_valid), 36'd0);
        chk("mid_reset_busy", 36'(busy), 36'd0);
        chk("mid_reset_in_ready", 36'(in_ready), 36'd1);
        chk("mid_reset_ops", 36'({op_A_out, op_B_out} != 64'd0), 36'd0);
        chk("mid_reset_result", {res_status, res_data}, 36'd0);
        chk("mid_reset_counters", 36'({cnt_inexact, cnt_overflow, cnt_underflow}), 36'd0);
        exp_q.delete();
        m_inx = 0;
        m_ovf = 0;
        m_unf = 0;
        repeat (2) cycle();
        reset     = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        repeat (200) begin
            cycle();
            if (res_valid || busy) seen++;
        end
        chk("no_result_after_reset", 36'(seen), 36'd0);
        run_one("t_after_reset", 32'h40000000, 32'h40000000, 32'h42000000, 4'b0001);

        // Random traffic with random downstream backpressure.
        base     = nacc;
        sent     = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 40 * (HOLD_CYCLES + 2) * 4 && (nacc - base) < 40; c++) begin
            if (!in_valid && sent < 40 && $urandom_range(0, 2) == 0) begin
                ra = $urandom;
                rb = ($urandom_range(0, 1) == 1) ? {ra[31], ra[30:25], 25'($urandom)} : $urandom;
                in_valid = 1'b1;
                in_op_a  = ra;
                in_op_b  = rb;
            end
            res_ready = ($urandom_range(0, 1) == 1);
            cycle();
            if (last_push) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("rand_results", 36'(nacc - base), 36'd40);
        chk("rand_queue_empty", 36'(exp_q.size()), 36'd0);
        chk("rand_cnt_inexact", 36'(cnt_inexact), cnt_exp(m_inx));
        chk("rand_cnt_overflow", 36'(cnt_overflow), cnt_exp(m_ovf));
        chk("rand_cnt_underflow", 36'(cnt_underflow), cnt_exp(m_unf));

`ifdef FPU_SEQ_STATS_EN
        // 300 overflow transactions drive cnt_overflow into saturation.
        base      = nacc;
        sent      = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 300 * (HOLD_CYCLES + 2) + 500 && (nacc - base) < 300; c++) begin
            if (!in_valid && sent < 300) begin
                in_valid = 1'b1;
                in_op_a  = 32'h7E000000;
                in_op_b  = 32'h7E000000;
            end
            cycle();
            if (last_push) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("sat_results", 36'(nacc - base), 36'd300);
        chk("sat_cnt_overflow", 36'(cnt_overflow), 36'd255);
        chk("sat_cnt_model", 36'(cnt_overflow), cnt_exp(m_ovf));
        chk("sat_cnt_inexact", 36'(cnt_inexact), cnt_exp(m_inx));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
